// File: rtl/riscv151.sv
// riscv151 - multicycle RV32I processor running from an internal BIOS ROM.
//
// Each instruction takes FETCH -> EXEC (2 cycles), and loads add a LOAD
// cycle (3 cycles). The BIOS ROM and the data RAM both have one-cycle
// synchronous reads. The ROM read port is shared: FETCH reads the PC word,
// and EXEC of a load reads the data word.
//
// Ports:
//   clk             core clock, all state on the rising edge
//   rst             asynchronous, active-high reset
//   FPGA_SERIAL_RX  UART receive (no UART yet, ignored)
//   FPGA_SERIAL_TX  UART transmit, held idle high
//   clean_buttons   debounced push buttons, read at 0x8000_0024
//   switches        slide switches, read at 0x8000_0028
//   leds            LED register, read/write at 0x8000_0030
//
// Memory map on address[31:28]:
//   4 = BIOS ROM, 1 = data RAM, 8 = I/O. Unmapped regions read 0.
//   Writes to unmapped regions are dropped.
//
// The FSM state is the internal signal 'state', and the program counter is
// 'pc'. Both can be observed hierarchically.

module reg_file (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2
);
    logic [31:0] registers [0:31];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) registers[i] <= 32'd0;
        end else if (we && (waddr != 5'd0)) begin
            registers[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : registers[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : registers[raddr2];
endmodule

// BIOS ROM: 4096 words with a registered read. The contents are loaded
// from outside the design, for example by the FPGA flow's memory init.
module bios_rom (
    input  logic        clk,
    input  logic [11:0] addr,
    output logic [31:0] rdata
);
    logic [31:0] mem [0:4095];

    always_ff @(posedge clk) rdata <= mem[addr];
endmodule

module riscv151 #(
    parameter int          CPU_CLOCK_FREQ = 50_000_000,
    parameter logic [31:0] RESET_PC       = 32'h4000_0000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       FPGA_SERIAL_RX,
    output logic       FPGA_SERIAL_TX,
    input  logic [2:0] clean_buttons,
    input  logic [1:0] switches,
    output logic [5:0] leds
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic [1:0] {FETCH = 2'd0, EXEC = 2'd1, LOAD = 2'd2} state_t;

    state_t      state, state_next;
    logic [31:0] pc, pc_next;
    logic        fetch_ok;      // the fetched PC was inside the BIOS region
    logic [4:0]  ld_rd;
    logic [2:0]  ld_funct3;
    logic [31:0] ld_addr;

    // There is no UART yet. RX is ORed into a constant so the pin is consumed.
    assign FPGA_SERIAL_TX = 1'b1 | FPGA_SERIAL_RX;

    // Decode
    logic [31:0] inst;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    logic [11:0] bios_addr;
    logic [31:0] bios_rdata;

    // A fetch from outside the BIOS region yields 0, which decodes as a NOP.
    assign inst   = fetch_ok ? bios_rdata : 32'd0;
    assign opcode = inst[6:0];
    assign rd     = inst[11:7];
    assign funct3 = inst[14:12];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];
    assign imm_i  = {{20{inst[31]}}, inst[31:20]};
    assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u  = {inst[31:12], 12'd0};
    assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, rs1_val, rs2_val;

    reg_file rf (
        .clk    (clk),
        .rst    (rst),
        .we     (rf_we),
        .waddr  (rf_waddr),
        .wdata  (rf_wdata),
        .raddr1 (rs1),
        .raddr2 (rs2),
        .rdata1 (rs1_val),
        .rdata2 (rs2_val)
    );

    // Load, store and JALR all use rs1 + immediate as their address.
    logic [31:0] mem_addr, pc_plus4;
    assign mem_addr = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);
    assign pc_plus4 = pc + 32'd4;

    assign bios_addr = (state == EXEC) ? mem_addr[13:2] : pc[13:2];

    bios_rom bios_mem (
        .clk   (clk),
        .addr  (bios_addr),
        .rdata (bios_rdata)
    );

    // ALU. For OP-IMM, inst[30] is an immediate bit for ADDI, so it selects
    // SUB only for register-register ops. For shifts it selects SRA/SRAI.
    logic [31:0] alu_b, alu_out;
    logic [4:0]  shamt;
    assign alu_b = (opcode == OP_REG) ? rs2_val : imm_i;
    assign shamt = alu_b[4:0];

    always_comb begin
        alu_out = 32'd0;
        case (funct3)
            3'b000: alu_out = ((opcode == OP_REG) && inst[30]) ? rs1_val - alu_b
                                                               : rs1_val + alu_b;
            3'b001: alu_out = rs1_val << shamt;
            3'b010: alu_out = {31'd0, $signed(rs1_val) < $signed(alu_b)};
            3'b011: alu_out = {31'd0, rs1_val < alu_b};
            3'b100: alu_out = rs1_val ^ alu_b;
            3'b101: begin
                if (inst[30]) alu_out = $unsigned($signed(rs1_val) >>> shamt);
                else          alu_out = rs1_val >> shamt;
            end
            3'b110: alu_out = rs1_val | alu_b;
            default: alu_out = rs1_val & alu_b;
        endcase
    end

    logic br_taken;
    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            3'b000: br_taken = (rs1_val == rs2_val);
            3'b001: br_taken = (rs1_val != rs2_val);
            3'b100: br_taken = ($signed(rs1_val) <  $signed(rs2_val));
            3'b101: br_taken = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110: br_taken = (rs1_val <  rs2_val);
            3'b111: br_taken = (rs1_val >= rs2_val);
            default: br_taken = 1'b0;
        endcase
    end

    // Store lanes. The data is replicated across all lanes, and the byte
    // enables pick which lane is actually written.
    logic [31:0] st_wdata;
    logic [3:0]  st_be;
    always_comb begin
        st_wdata = rs2_val;
        st_be    = 4'b0000;
        case (funct3[1:0])
            2'b00: begin
                st_wdata = {4{rs2_val[7:0]}};
                st_be    = 4'b0001 << mem_addr[1:0];
            end
            2'b01: begin
                st_wdata = {2{rs2_val[15:0]}};
                st_be    = mem_addr[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: st_be = 4'b1111;
            default: st_be = 4'b0000;
        endcase
    end

    // Data RAM
    logic        dmem_we, leds_we;
    logic [31:0] dmem_rdata;
    logic [31:0] dmem [0:4095];

    always_ff @(posedge clk) begin
        if (dmem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (st_be[b]) dmem[mem_addr[13:2]][8*b +: 8] <= st_wdata[8*b +: 8];
            end
        end
        dmem_rdata <= dmem[mem_addr[13:2]];
    end

    // Load return path, evaluated in LOAD. I/O is sampled in this cycle.
    logic [31:0] ld_word, ld_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    always_comb begin
        ld_word = 32'd0;
        case (ld_addr[31:28])
            4'h4: ld_word = bios_rdata;
            4'h1: ld_word = dmem_rdata;
            4'h8: begin
                case ({ld_addr[31:2], 2'b00})
                    32'h8000_0024: ld_word = {29'd0, clean_buttons};
                    32'h8000_0028: ld_word = {30'd0, switches};
                    32'h8000_0030: ld_word = {26'd0, leds};
                    default:       ld_word = 32'd0;
                endcase
            end
            default: ld_word = 32'd0;
        endcase

        case (ld_addr[1:0])
            2'd0:    ld_byte = ld_word[7:0];
            2'd1:    ld_byte = ld_word[15:8];
            2'd2:    ld_byte = ld_word[23:16];
            default: ld_byte = ld_word[31:24];
        endcase
        ld_half = ld_addr[1] ? ld_word[31:16] : ld_word[15:0];

        case (ld_funct3)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'd0, ld_byte};
            3'b101:  ld_data = {16'd0, ld_half};
            default: ld_data = ld_word;
        endcase
    end

    // FSM next state, PC and write enables
    always_comb begin
        state_next = state;
        pc_next    = pc;
        rf_we      = 1'b0;
        rf_waddr   = rd;
        rf_wdata   = alu_out;
        dmem_we    = 1'b0;
        leds_we    = 1'b0;
        case (state)
            FETCH: state_next = EXEC;
            EXEC: begin
                state_next = FETCH;
                pc_next    = pc_plus4;
                case (opcode)
                    OP_LUI: begin
                        rf_we    = 1'b1;
                        rf_wdata = imm_u;
                    end
                    OP_AUIPC: begin
                        rf_we    = 1'b1;
                        rf_wdata = pc + imm_u;
                    end
                    OP_JAL: begin
                        rf_we    = 1'b1;
                        rf_wdata = pc_plus4;
                        pc_next  = pc + imm_j;
                    end
                    OP_JALR: begin
                        rf_we    = 1'b1;
                        rf_wdata = pc_plus4;
                        pc_next  = {mem_addr[31:1], 1'b0};
                    end
                    OP_BRANCH: begin
                        if (br_taken) pc_next = pc + imm_b;
                    end
                    OP_LOAD: state_next = LOAD;
                    OP_STORE: begin
                        dmem_we = (mem_addr[31:28] == 4'h1);
                        leds_we = ({mem_addr[31:2], 2'b00} == 32'h8000_0030);
                    end
                    OP_IMM, OP_REG: rf_we = 1'b1;
                    default: ;  // FENCE, SYSTEM and unknown opcodes are NOPs
                endcase
            end
            LOAD: begin
                state_next = FETCH;
                rf_we      = 1'b1;
                rf_waddr   = ld_rd;
                rf_wdata   = ld_data;
            end
            default: state_next = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            fetch_ok  <= 1'b0;
            ld_rd     <= 5'd0;
            ld_funct3 <= 3'd0;
            ld_addr   <= 32'd0;
            leds      <= 6'd0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (state == FETCH) fetch_ok <= (pc[31:28] == 4'h4);
            // Keep the load context, because the ROM output is overwritten in LOAD.
            if (state == EXEC) begin
                ld_rd     <= rd;
                ld_funct3 <= funct3;
                ld_addr   <= mem_addr;
            end
            if (leds_we) leds <= st_wdata[5:0];
        end
    end
endmodule

// File: tb/tb_riscv151.sv
// Testbench for riscv151.
// Each program is written straight into the BIOS ROM array. The bench holds
// reset while writing, then releases it and runs until the PC reaches the
// closing self-loop. Expected register values are queued as the program is
// built, then popped and compared against rf.registers.
module tb_riscv151;
    localparam logic [31:0] BASE = 32'h4000_0000;

    // Clock and reset
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic       tx;
    logic [2:0] buttons  = 3'd0;
    logic [1:0] switches = 2'd0;
    logic [5:0] leds;

    always #5 clk = ~clk;

    riscv151 dut (
        .clk            (clk),
        .rst            (rst),
        .FPGA_SERIAL_RX (rx),
        .FPGA_SERIAL_TX (tx),
        .clean_buttons  (buttons),
        .switches       (switches),
        .leds           (leds)
    );

    // Scoreboard
    int          compared   = 0;
    int          mismatched = 0;
    logic [36:0] exp_q[$];          // {reg index, expected value}
    int          pl;                // next ROM word to write
    logic [31:0] end_pc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_reg(input logic [4:0] idx, input logic [31:0] val);
        exp_q.push_back({idx, val});
    endtask

    task automatic check_regs(input string tag);
        logic [36:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("%s x%0d", tag, e[36:32]), dut.rf.registers[e[36:32]], e[31:0]);
        end
    endtask

    // Instruction encoders
    function automatic logic [31:0] i_t(input int imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] r_t(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] s_t(input int imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] b_t(input int off, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [2:0] f3);
        return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] j_t(input int off, input logic [4:0] rd);
        return {off[20], off[10:1], off[11], off[19:12], rd, 7'b1101111};
    endfunction
    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input int imm);
        return i_t(imm, rs1, 3'b000, rd, 7'b0010011);
    endfunction
    function automatic logic [31:0] lui(input logic [4:0] rd, input logic [19:0] imm);
        return {imm, rd, 7'b0110111};
    endfunction
    function automatic logic [31:0] ld(input logic [2:0] f3, input logic [4:0] rd,
                                       input logic [4:0] rs1, input int imm);
        return i_t(imm, rs1, f3, rd, 7'b0000011);
    endfunction

    // Driver tasks
    task automatic begin_prog();
        rst = 1'b1;
        pl  = 0;
        @(negedge clk);
    endtask

    task automatic put(input logic [31:0] w);
        dut.bios_mem.mem[pl] = w;
        pl++;
    endtask

    function automatic logic [31:0] here();
        return BASE + 32'(pl) * 32'd4;
    endfunction

    task automatic run_prog(input string tag);
        logic done;
        done   = 1'b0;
        end_pc = here();
        put(j_t(0, 5'd0));                  // jal x0, 0 : park here
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 2000 && !done; c++) begin
            @(posedge clk);
            #1;
            if (dut.pc == end_pc) done = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        check({tag, " reached end"}, {31'd0, done}, 32'd1);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        logic [31:0] a;

        // Reset state, then the first instruction retires two cycles after release
        begin_prog();
        put(addi(5'd20, 5'd0, 1));
        put(j_t(0, 5'd0));
        @(posedge clk);
        #1;
        check("reset pc", dut.pc, BASE);
        check("reset leds", {26'd0, leds}, 32'd0);
        check("reset tx idle", {31'd0, tx}, 32'd1);
        check("reset x20", dut.rf.registers[20], 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("x20 after fetch", dut.rf.registers[20], 32'd0);
        @(posedge clk);
        #1;
        check("x20 after exec", dut.rf.registers[20], 32'd1);

        // I/O reads, LED write, data read from the ROM, unmapped reads
        begin_prog();
        switches = 2'b10;
        buttons  = 3'b101;
        put(lui(5'd1, 20'h80000));                  expect_reg(5'd1, 32'h8000_0000);
        put(ld(3'b010, 5'd2, 5'd1, 32'h28));        expect_reg(5'd2, 32'h2);
        put(ld(3'b010, 5'd3, 5'd1, 32'h24));        expect_reg(5'd3, 32'h5);
        put(addi(5'd4, 5'd0, 32'h2A));              expect_reg(5'd4, 32'h2A);
        put(s_t(32'h30, 5'd4, 5'd1, 3'b010));
        put(ld(3'b010, 5'd8, 5'd1, 32'h30));        expect_reg(5'd8, 32'h2A);
        put(addi(5'd9, 5'd0, 7));
        put(ld(3'b010, 5'd9, 5'd1, 32'h34));        expect_reg(5'd9, 32'h0);
        put(lui(5'd10, 20'h20000));
        put(addi(5'd11, 5'd0, 9));
        put(ld(3'b010, 5'd11, 5'd10, 0));           expect_reg(5'd11, 32'h0);
        put(lui(5'd13, 20'h40000));
        put(ld(3'b010, 5'd12, 5'd13, 0));           expect_reg(5'd12, lui(5'd1, 20'h80000));
        run_prog("io");
        check_regs("io");
        check("leds after sw", {26'd0, leds}, 32'h2A);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("leds async reset", {26'd0, leds}, 32'd0);
        check("pc async reset", dut.pc, BASE);
        check("x4 async reset", dut.rf.registers[4], 32'd0);

        // Data RAM byte lanes and extension
        begin_prog();
        put(lui(5'd6, 20'h10000));
        put(addi(5'd5, 5'd0, -1));
        put(s_t(0, 5'd0, 5'd6, 3'b010));
        put(s_t(1, 5'd5, 5'd6, 3'b000));
        put(ld(3'b010, 5'd7,  5'd6, 0));            expect_reg(5'd7,  32'h0000_FF00);
        put(ld(3'b000, 5'd9,  5'd6, 1));            expect_reg(5'd9,  32'hFFFF_FFFF);
        put(ld(3'b100, 5'd10, 5'd6, 1));            expect_reg(5'd10, 32'h0000_00FF);
        put(ld(3'b001, 5'd11, 5'd6, 0));            expect_reg(5'd11, 32'hFFFF_FF00);
        put(ld(3'b101, 5'd12, 5'd6, 0));            expect_reg(5'd12, 32'h0000_FF00);
        put(s_t(2, 5'd5, 5'd6, 3'b001));
        put(ld(3'b010, 5'd13, 5'd6, 0));            expect_reg(5'd13, 32'hFFFF_FF00);
        put(ld(3'b001, 5'd14, 5'd6, 2));            expect_reg(5'd14, 32'hFFFF_FFFF);
        put(ld(3'b010, 5'd15, 5'd6, 2));            expect_reg(5'd15, 32'hFFFF_FF00);
        run_prog("dmem");
        check_regs("dmem");

        // Control flow and x0
        begin_prog();
        put(addi(5'd0, 5'd0, 5));                   expect_reg(5'd0, 32'd0);
        put(b_t(8, 5'd0, 5'd0, 3'b001));
        put(addi(5'd14, 5'd0, 1));                  expect_reg(5'd14, 32'd1);
        put(b_t(8, 5'd0, 5'd0, 3'b000));
        put(addi(5'd15, 5'd0, 1));                  expect_reg(5'd15, 32'd0);
        put(addi(5'd16, 5'd0, 3));                  expect_reg(5'd16, 32'd3);
        a = here();
        put(j_t(8, 5'd17));                         expect_reg(5'd17, a + 32'd4);
        put(addi(5'd18, 5'd0, 1));                  expect_reg(5'd18, 32'd0);
        put(addi(5'd19, 5'd0, 7));                  expect_reg(5'd19, 32'd7);
        a = here();
        put({20'd0, 5'd21, 7'b0010111});            expect_reg(5'd21, a);
        put(i_t(13, 5'd21, 3'b000, 5'd22, 7'b1100111)); expect_reg(5'd22, a + 32'd8);
        put(addi(5'd23, 5'd0, 1));                  expect_reg(5'd23, 32'd0);
        put(addi(5'd24, 5'd0, 9));                  expect_reg(5'd24, 32'd9);
        run_prog("ctrl");
        check_regs("ctrl");

        // ALU corner cases and the remaining branch types
        begin_prog();
        put(addi(5'd1, 5'd0, 1));
        put(r_t(7'h20, 5'd1, 5'd0, 3'b000, 5'd2));  expect_reg(5'd2, 32'hFFFF_FFFF);
        put(lui(5'd3, 20'h80000));
        put(addi(5'd4, 5'd0, 31));
        put(r_t(7'h20, 5'd4, 5'd3, 3'b101, 5'd5));  expect_reg(5'd5, 32'hFFFF_FFFF);
        put(r_t(7'h00, 5'd2, 5'd1, 3'b011, 5'd6));  expect_reg(5'd6, 32'd1);
        put(r_t(7'h00, 5'd1, 5'd2, 3'b010, 5'd7));  expect_reg(5'd7, 32'd1);
        put(r_t(7'h00, 5'd4, 5'd3, 3'b101, 5'd8));  expect_reg(5'd8, 32'd1);
        put(i_t(32'h404, 5'd3, 3'b101, 5'd9, 7'b0010011));  expect_reg(5'd9, 32'hF800_0000);
        put(i_t(31, 5'd1, 3'b001, 5'd10, 7'b0010011));      expect_reg(5'd10, 32'h8000_0000);
        put(i_t(32'hF0, 5'd2, 3'b100, 5'd11, 7'b0010011));  expect_reg(5'd11, 32'hFFFF_FF0F);
        put(i_t(-1, 5'd0, 3'b011, 5'd12, 7'b0010011));      expect_reg(5'd12, 32'd1);
        put(i_t(32'h7FF, 5'd2, 3'b111, 5'd13, 7'b0010011)); expect_reg(5'd13, 32'h0000_07FF);
        put(i_t(-2048, 5'd0, 3'b110, 5'd14, 7'b0010011));   expect_reg(5'd14, 32'hFFFF_F800);
        put(addi(5'd15, 5'd0, 33));
        put(r_t(7'h00, 5'd15, 5'd1, 3'b001, 5'd16)); expect_reg(5'd16, 32'd2);
        put(r_t(7'h00, 5'd2, 5'd2, 3'b000, 5'd17));  expect_reg(5'd17, 32'hFFFF_FFFE);
        put(b_t(8, 5'd2, 5'd1, 3'b100));
        put(addi(5'd18, 5'd0, 1));                   expect_reg(5'd18, 32'd0);
        put(b_t(8, 5'd2, 5'd1, 3'b111));
        put(addi(5'd19, 5'd0, 1));                   expect_reg(5'd19, 32'd0);
        put(b_t(8, 5'd2, 5'd1, 3'b110));
        put(addi(5'd20, 5'd0, 5));                   expect_reg(5'd20, 32'd5);
        put(b_t(8, 5'd1, 5'd2, 3'b101));
        put(addi(5'd21, 5'd0, 1));                   expect_reg(5'd21, 32'd0);
        put(i_t(0, 5'd2, 3'b010, 5'd22, 7'b0010011)); expect_reg(5'd22, 32'd1);
        put(r_t(7'h00, 5'd3, 5'd2, 3'b111, 5'd24));  expect_reg(5'd24, 32'h8000_0000);
        put(r_t(7'h00, 5'd3, 5'd1, 3'b110, 5'd25));  expect_reg(5'd25, 32'h8000_0001);
        put(r_t(7'h00, 5'd3, 5'd2, 3'b100, 5'd26));  expect_reg(5'd26, 32'h7FFF_FFFF);
        run_prog("alu");
        check_regs("alu");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
